// File: rtl/fwd_hazard_unit.sv
// Operand/store-data forwarding and load-use hazard unit beside the ID/EX register; selects are registered (1 cycle), stall/bubble are combinational.
// mem_busy freezes all tracked state except that flush still empties EX; the stall counter only counts on advancing edges.
module fwd_hazard_unit #(
    parameter int AW       = 4,
    parameter int NSRC     = 2,
    parameter int LINK_REG = 15,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_id_valid,
    input  logic [NSRC*AW-1:0]   i_id_src,
    input  logic [AW-1:0]        i_id_dst,
    input  logic                 i_id_wr,
    input  logic                 i_id_load,
    input  logic                 i_id_link,
    input  logic                 i_id_store,
    input  logic                 i_mem_busy,
    input  logic                 i_flush,
    output logic [2*NSRC-1:0]    o_fwd_sel,
    output logic                 o_st_fwd,
    output logic                 o_stall,
    output logic                 o_ex_bubble,
    output logic [CNT_W-1:0]     o_stall_cnt
);
    localparam logic [AW-1:0] LINK_IDX = AW'(LINK_REG);
    localparam logic [1:0]    SEL_RF   = 2'b00;
    localparam logic [1:0]    SEL_WB   = 2'b01;
    localparam logic [1:0]    SEL_EXM  = 2'b10;
    localparam logic [1:0]    SEL_LINK = 2'b11;

    typedef struct packed {
        logic          vld;
        logic [AW-1:0] dst;
        logic          wr;
        logic          load;
        logic          link;
        logic          store;
    } stage_t;

    stage_t             r_ex;
    stage_t             r_mem;
    stage_t             r_wb;
    stage_t             w_id_ent;
    logic [2*NSRC-1:0]  r_fwd_sel;
    logic [2*NSRC-1:0]  w_fwd_nxt;
    logic               r_st_fwd;
    logic               w_st_fwd_nxt;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [NSRC-1:0]    w_ld_hit;
    logic               w_ex_link;
    logic               w_ex_prod;
    logic               w_ex_ld_prod;
    logic               w_mem_prod;
    logic               w_stall;
    logic               w_bubble;
    logic               w_cnt_inc;
    logic               w_unused_state;

    always_comb begin
        w_id_ent       = '0;
        w_id_ent.vld   = i_id_valid;
        w_id_ent.dst   = i_id_dst;
        w_id_ent.wr    = i_id_wr;
        w_id_ent.load  = i_id_load;
        w_id_ent.link  = i_id_link;
        w_id_ent.store = i_id_store;
    end

    // A load in EX cannot feed EX/MEM; only its WB copy is usable, hence the stall.
    assign w_ex_link    = r_ex.vld & r_ex.link;
    assign w_ex_prod    = r_ex.vld & r_ex.wr & ~r_ex.load & (r_ex.dst != '0);
    assign w_ex_ld_prod = r_ex.vld & r_ex.wr &  r_ex.load & (r_ex.dst != '0);
    assign w_mem_prod   = r_mem.vld & r_mem.wr & (r_mem.dst != '0);

    always_comb begin
        w_fwd_nxt = '0;
        w_ld_hit  = '0;
        for (int k = 0; k < NSRC; k++) begin
            w_ld_hit[k] = w_ex_ld_prod & (i_id_src[k*AW +: AW] == r_ex.dst);
            if (w_ex_link && (i_id_src[k*AW +: AW] == LINK_IDX)) begin
                w_fwd_nxt[2*k +: 2] = SEL_LINK;
            end else if (w_ex_prod && (i_id_src[k*AW +: AW] == r_ex.dst)) begin
                w_fwd_nxt[2*k +: 2] = SEL_EXM;
            end else if (w_mem_prod && (i_id_src[k*AW +: AW] == r_mem.dst)) begin
                w_fwd_nxt[2*k +: 2] = SEL_WB;
            end else begin
                w_fwd_nxt[2*k +: 2] = SEL_RF;
            end
        end
    end

    assign w_stall      = i_id_valid & (|w_ld_hit);
    assign w_bubble     = (w_stall | i_flush | ~i_id_valid) & ~i_mem_busy;
    assign w_st_fwd_nxt = r_ex.vld & r_ex.store & w_mem_prod & (r_mem.dst == r_ex.dst);
    assign w_cnt_inc    = w_stall & ~i_mem_busy & ~i_flush & (r_stall_cnt != '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex      <= '0;
            r_mem     <= '0;
            r_wb      <= '0;
            r_fwd_sel <= '0;
            r_st_fwd  <= 1'b0;
        end else if (!i_mem_busy) begin
            r_wb      <= r_mem;
            r_mem     <= r_ex;
            r_ex      <= w_bubble ? stage_t'('0) : w_id_ent;
            r_fwd_sel <= w_bubble ? '0 : w_fwd_nxt;
            r_st_fwd  <= w_st_fwd_nxt;
        end else if (i_flush) begin
            // Redirect during a freeze still kills EX; MEM/WB and st_fwd hold.
            r_ex      <= '0;
            r_fwd_sel <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    // WB and the MEM attribute bits are tracked for pipeline visibility but feed no output.
    assign w_unused_state = ^{r_wb, r_mem.load, r_mem.link, r_mem.store};

    assign o_fwd_sel   = r_fwd_sel;
    assign o_st_fwd    = r_st_fwd;
    assign o_stall     = w_stall;
    assign o_ex_bubble = w_bubble;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Randomised + directed bench for fwd_hazard_unit against a behavioural pipeline model.
module tb_fwd_hazard_unit;
    localparam int AW       = 4;
    localparam int NSRC     = 2;
    localparam int LINK_REG = 15;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                id_valid = 1'b0;
    logic [NSRC*AW-1:0]  id_src = '0;
    logic [AW-1:0]       id_dst = '0;
    logic                id_wr = 1'b0, id_load = 1'b0, id_link = 1'b0, id_store = 1'b0;
    logic                mem_busy = 1'b0, flush = 1'b0;
    logic [2*NSRC-1:0]   fwd_sel;
    logic                st_fwd, stall, ex_bubble;
    logic [CNT_W-1:0]    stall_cnt;

    fwd_hazard_unit #(.AW(AW), .NSRC(NSRC), .LINK_REG(LINK_REG), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_id_valid(id_valid), .i_id_src(id_src), .i_id_dst(id_dst),
        .i_id_wr(id_wr), .i_id_load(id_load), .i_id_link(id_link), .i_id_store(id_store),
        .i_mem_busy(mem_busy), .i_flush(flush),
        .o_fwd_sel(fwd_sel), .o_st_fwd(st_fwd), .o_stall(stall),
        .o_ex_bubble(ex_bubble), .o_stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: instructions in flight, index 0 = EX, 1 = MEM, 2 = WB.
    typedef struct { bit v; int dst; bit wr; bit ld; bit lk; bit st; } ins_t;
    ins_t pipe[3];
    ins_t cur;
    int   cur_src[NSRC];
    int   m_sel[NSRC];
    bit   m_stf;
    int   m_cnt;

    function automatic ins_t empty_ins();
        ins_t e;
        e.v = 0; e.dst = 0; e.wr = 0; e.ld = 0; e.lk = 0; e.st = 0;
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = empty_ins();
        for (int k = 0; k < NSRC; k++) m_sel[k] = 0;
        m_stf = 0;
        m_cnt = 0;
    endtask

    // Where the youngest usable value of register s lives for the instruction entering EX.
    function automatic int m_source(int s);
        if (pipe[0].v && pipe[0].lk && s == LINK_REG) return 3;
        if (s == 0) return 0;
        if (pipe[0].v && pipe[0].wr && !pipe[0].ld && pipe[0].dst == s) return 2;
        if (pipe[1].v && pipe[1].wr && pipe[1].dst == s) return 1;
        return 0;
    endfunction

    function automatic bit m_stall();
        bit uses = 0;
        if (!(cur.v && pipe[0].v && pipe[0].ld && pipe[0].wr && pipe[0].dst != 0)) return 0;
        for (int k = 0; k < NSRC; k++) if (cur_src[k] == pipe[0].dst) uses = 1;
        return uses;
    endfunction

    task automatic model_edge();
        bit stl, bub;
        stl = m_stall();
        bub = stl || flush || !cur.v;
        if (!mem_busy) begin
            for (int k = 0; k < NSRC; k++) m_sel[k] = bub ? 0 : m_source(cur_src[k]);
            m_stf = pipe[0].v && pipe[0].st && pipe[1].v && pipe[1].wr &&
                    pipe[1].dst != 0 && pipe[1].dst == pipe[0].dst;
            if (stl && !flush && m_cnt < CNT_MAX) m_cnt++;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = bub ? empty_ins() : cur;
        end else if (flush) begin
            pipe[0] = empty_ins();
            for (int k = 0; k < NSRC; k++) m_sel[k] = 0;
        end
    endtask

    task automatic check_regs();
        logic [2*NSRC-1:0] e;
        e = '0;
        for (int k = 0; k < NSRC; k++) e[2*k +: 2] = 2'(m_sel[k]);
        check("fwd_sel", 32'(fwd_sel), 32'(e));
        check("st_fwd", 32'(st_fwd), 32'(m_stf));
        check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    endtask

    task automatic step(input bit v, input int s0, input int s1, input int d,
                        input bit wr, input bit ld, input bit lk, input bit st,
                        input bit busy, input bit fl, output bit gs, output bit gb);
        @(negedge clk);
        cur_src[0] = s0;
        cur_src[1] = s1;
        cur.v = v; cur.dst = d; cur.wr = wr; cur.ld = ld; cur.lk = lk; cur.st = st;
        id_valid = v;
        for (int k = 0; k < NSRC; k++) id_src[k*AW +: AW] = cur_src[k][AW-1:0];
        id_dst = d[AW-1:0];
        id_wr = wr; id_load = ld; id_link = lk; id_store = st;
        mem_busy = busy; flush = fl;
        #1;
        gs = stall;
        gb = ex_bubble;
        check("stall", 32'(stall), 32'(m_stall()));
        check("ex_bubble", 32'(ex_bubble), 32'((m_stall() || fl || !v) && !busy));
        @(posedge clk);
        model_edge();
        #1;
        check_regs();
    endtask

    task automatic alu(input int d, input int s0, input int s1);
        bit gs, gb;
        step(1, s0, s1, d, 1, 0, 0, 0, 0, 0, gs, gb);
    endtask

    task automatic load(input int d, input int s0);
        bit gs, gb;
        step(1, s0, 0, d, 1, 1, 0, 0, 0, 0, gs, gb);
    endtask

    task automatic nop();
        bit gs, gb;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, gs, gb);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_sel"}, 32'(fwd_sel), 32'd0);
        check({tag, "_stf"}, 32'(st_fwd), 32'd0);
        check({tag, "_stall"}, 32'(stall), 32'd0);
        check({tag, "_bub"}, 32'(ex_bubble), 32'd0);
        check({tag, "_cnt"}, 32'(stall_cnt), 32'd0);
    endtask

    function automatic int pick_reg();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 4) return r;
        if (r <= 6) return LINK_REG;
        return $urandom_range(0, 15);
    endfunction

    initial begin
        bit gs, gb;
        int cnt0;
        model_reset();
        cur = empty_ins();
        for (int k = 0; k < NSRC; k++) cur_src[k] = 0;

        // Reset state (id_valid high so ex_bubble is not raised by an empty ID).
        id_valid = 1'b1;
        #2;
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back ALU, then a use one instruction further away.
        alu(3, 1, 2);
        alu(5, 3, 3);
        check("b2b_exm", 32'(fwd_sel), 32'b1010);
        alu(8, 3, 1);
        check("b2b_wb", 32'(fwd_sel), 32'b0001);

        // Load-use: one stall cycle, then the consumer forwards from MEM/WB.
        load(4, 1);
        step(1, 4, 1, 6, 1, 0, 0, 0, 0, 0, gs, gb);
        check("lu_stall", 32'(gs), 32'd1);
        check("lu_bubble", 32'(gb), 32'd1);
        check("lu_cnt", 32'(stall_cnt), 32'd1);
        step(1, 4, 1, 6, 1, 0, 0, 0, 0, 0, gs, gb);
        check("lu_release", 32'(gs), 32'd0);
        check("lu_sel", 32'(fwd_sel), 32'b0001);
        check("lu_cnt_hold", 32'(stall_cnt), 32'd1);

        // Register 0 is never a forwarding source nor a stall cause.
        alu(0, 1, 2);
        alu(2, 0, 0);
        check("zero_sel", 32'(fwd_sel), 32'd0);
        load(0, 1);
        step(1, 0, 0, 6, 1, 0, 0, 0, 0, 0, gs, gb);
        check("zero_nostall", 32'(gs), 32'd0);

        // Link path overrides an older MEM write of the link register.
        alu(15, 1, 2);
        step(1, 1, 2, 0, 0, 0, 1, 0, 0, 0, gs, gb);
        alu(7, 15, 0);
        check("link_sel", 32'(fwd_sel), 32'b0011);

        // Store data forwarding: adjacent producer vs two instructions away.
        alu(9, 1, 2);
        step(1, 1, 2, 9, 0, 0, 0, 1, 0, 0, gs, gb);
        nop();
        check("stf_near", 32'(st_fwd), 32'd1);
        alu(9, 1, 2);
        nop();
        step(1, 1, 2, 9, 0, 0, 0, 1, 0, 0, gs, gb);
        nop();
        check("stf_far", 32'(st_fwd), 32'd0);

        // Freeze for three cycles in the middle of a load-use stall.
        load(4, 1);
        cnt0 = m_cnt;
        for (int i = 0; i < 3; i++) begin
            step(1, 4, 1, 6, 1, 0, 0, 0, 1, 0, gs, gb);
            check("frz_stall", 32'(gs), 32'd1);
            check("frz_bubble", 32'(gb), 32'd0);
            check("frz_cnt", 32'(stall_cnt), 32'(cnt0));
        end
        step(1, 4, 1, 6, 1, 0, 0, 0, 0, 0, gs, gb);
        check("frz_cnt_inc", 32'(stall_cnt), 32'(cnt0 + 1));
        step(1, 4, 1, 6, 1, 0, 0, 0, 0, 0, gs, gb);

        // Flush clears selects, with and without a freeze.
        alu(3, 1, 2);
        step(1, 3, 3, 5, 1, 0, 0, 0, 0, 1, gs, gb);
        check("flush_sel", 32'(fwd_sel), 32'd0);
        alu(3, 1, 2);
        alu(5, 3, 3);
        step(1, 5, 3, 6, 1, 0, 0, 0, 1, 1, gs, gb);
        check("flush_busy_sel", 32'(fwd_sel), 32'd0);
        nop();

        // Drive the narrow counter into saturation.
        for (int i = 0; i < 20; i++) begin
            load(4, 1);
            step(1, 1, 4, 6, 1, 0, 0, 0, 0, 0, gs, gb);
            step(1, 1, 4, 6, 1, 0, 0, 0, 0, 0, gs, gb);
        end
        check("cnt_sat", 32'(stall_cnt), 32'(CNT_MAX));

        // Random traffic with an asynchronous reset in the middle.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                @(negedge clk);
                id_valid = 1'b1;
                flush = 1'b0;
                mem_busy = 1'b0;
                #2;
                rst_n = 1'b0;
                #1;
                check_zero_outputs("async_rst");
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
            step($urandom_range(0, 9) != 0, pick_reg(), pick_reg(), pick_reg(),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0,
                 $urandom_range(0, 6) == 0, $urandom_range(0, 11) == 0, gs, gb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
